prga_swap_fsm: RTL and testbench
================================

PRGA_SWAP_FSM -- requirements
Module: prga_swap_fsm

Interface
REQ-001 SHALL have parameter MSG_DEP, default 32, giving the number of keystream pairs produced per run.
REQ-002 SHALL have parameter MSG_WIDTH, default 8, giving the S-memory data/address width; all index arithmetic is mod 2^MSG_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a run when sampled high in IDLE.
REQ-006 SHALL have port s_q  input  MSG_WIDTH  read data from the S RAM.
REQ-007 SHALL have port pair_ack  input  1  consumer has finished with the current pair and its S reads.
REQ-008 SHALL have port s_address  output  MSG_WIDTH  S RAM address.
REQ-009 SHALL have port s_data  output  MSG_WIDTH  S RAM write data.
REQ-010 SHALL have port s_wren  output  1  S RAM write enable.
REQ-011 SHALL have port mem_req  output  1  high while this block owns the S RAM port.
REQ-012 SHALL have port s_i  output  MSG_WIDTH  post-swap S[i].
REQ-013 SHALL have port s_j  output  MSG_WIDTH  post-swap S[j].
REQ-014 SHALL have port pair_valid  output  1  s_i/s_j valid for the pair at byte_index.
REQ-015 SHALL have port byte_index  output  MSG_WIDTH  message byte index k of the current pair (0..MSG_DEP-1).
REQ-016 SHALL have port done  output  1  all MSG_DEP pairs consumed.

Function
REQ-017 SHALL step through IDLE, INC_I, RD_I_ADDR, RD_I_WAIT, RD_I_CAP, RD_J_ADDR, RD_J_WAIT, RD_J_CAP, WR_I, WR_J, PRESENT, NEXT and DONE, one state per cycle unless stated otherwise.
REQ-018 SHALL go IDLE->INC_I on start=1; otherwise hold IDLE. start SHALL be ignored in every other state.
REQ-019 INC_I SHALL set i <= i+1 (wraps 255->0).
REQ-020 RD_I_ADDR SHALL drive s_address=i. s_q SHALL be captured in RD_I_CAP, two edges after the address is driven. RD_I_CAP SHALL set si_old <= s_q and j <= j+s_q (mod 256).
REQ-021 RD_J_ADDR, RD_J_WAIT and RD_J_CAP SHALL do the same for address j, capturing sj_old.
REQ-022 WR_I SHALL drive s_address=i, s_data=sj_old, s_wren=1. WR_J SHALL drive s_address=j, s_data=si_old, s_wren=1.
REQ-023 When i==j, both writes SHALL still occur in order. The final S[i] equals the original value.
REQ-024 s_wren SHALL be 1 only in WR_I and WR_J.
REQ-025 mem_req SHALL be 1 in INC_I through WR_J and 0 in IDLE, PRESENT, NEXT and DONE.
REQ-026 PRESENT SHALL drive s_i=sj_old, s_j=si_old and pair_valid=1, holding until pair_ack=1.
REQ-027 pair_ack SHALL be ignored outside PRESENT.
REQ-028 NEXT SHALL set k <= k+1. It SHALL go to DONE if k+1==MSG_DEP, else to INC_I.
REQ-029 DONE SHALL hold done=1 and pair_valid=0 until reset.
REQ-030 The first pair_valid SHALL appear on the 10th rising edge after the edge sampling start (fixed latency; no stalls before PRESENT).
REQ-031 s_i, s_j and byte_index SHALL be stable for the whole time pair_valid=1.

Reset
REQ-032 Reset SHALL force IDLE immediately, including mid-run and mid-write.
REQ-033 Reset SHALL clear i, j, k, si_old and sj_old to 0.
REQ-034 During reset and in IDLE, every output SHALL be 0.
REQ-035 After reset deasserts, a new start SHALL begin from i=j=k=0.

Structure
REQ-036 MSG_WIDTH/MSG_DEP defaults and the state enum SHALL live in shared package rc4_pkg.
REQ-037 No sub-module is natural. S RAM port muxing on mem_req SHALL be done at the top level, not in this block.

Verification
REQ-038 Bench SHALL use an S model preset to S[x]=x with 2-cycle read latency, MSG_DEP=3, and immediate pair_ack.
REQ-039 Pair 0 check: start -> pair 0 on the 10th edge with s_i=1, s_j=1, byte_index=0 (i==j path); S[1] stays 1.
REQ-040 Pair 1 check: the second pair SHALL have s_i=3, s_j=2, byte_index=1, leaving S[2]=3 and S[3]=2.
REQ-041 Pair 2 check: the third pair SHALL have s_i=5, s_j=2, byte_index=2, leaving S[3]=5 and S[5]=2. done SHALL rise in the cycle after NEXT and stay high.
REQ-042 Backpressure check: hold pair_ack=0 for 20 cycles in PRESENT -> pair_valid and outputs stay stable, mem_req=0, s_wren=0, and no S change occurs.
REQ-043 Reset check: assert reset during WR_I of pair 1 -> all outputs 0 at once. A fresh start then yields pair 0 again with i=1 and byte_index=0.
REQ-044 Wrap check: preset S[x]=255 for all x and MSG_DEP=3 -> j sequence 255, 254, 253 (mod-256 wrap); every pair has s_i=255 and s_j=255.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: default sizing and the PRGA swap FSM state encoding.
package rc4_pkg;

    localparam int unsigned DEF_MSG_WIDTH = 8;
    localparam int unsigned DEF_MSG_DEP   = 32;

    typedef enum logic [3:0] {
        StIdle,
        StIncI,
        StRdIAddr,
        StRdIWait,
        StRdICap,
        StRdJAddr,
        StRdJWait,
        StRdJCap,
        StWrI,
        StWrJ,
        StPresent,
        StNext,
        StDone
    } prga_state_e;

    // States in which the PRGA owns the shared S RAM port.
    function automatic logic owns_mem(prga_state_e st);
        return st inside {[StIncI:StWrJ]};
    endfunction

endpackage

// File: rtl/prga_swap_fsm.sv
// RC4 PRGA swap sequencer: per message byte, increments i, reads S[i] and S[j],
// swaps them in S and presents the post-swap pair until the consumer acks it.
module prga_swap_fsm
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_DEP   = DEF_MSG_DEP,
    parameter int unsigned MSG_WIDTH = DEF_MSG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MSG_WIDTH-1:0] s_q,
    input  logic                 pair_ack,
    output logic [MSG_WIDTH-1:0] s_address,
    output logic [MSG_WIDTH-1:0] s_data,
    output logic                 s_wren,
    output logic                 mem_req,
    output logic [MSG_WIDTH-1:0] s_i,
    output logic [MSG_WIDTH-1:0] s_j,
    output logic                 pair_valid,
    output logic [MSG_WIDTH-1:0] byte_index,
    output logic                 done
);

    prga_state_e          state_q, state_d;
    logic [MSG_WIDTH-1:0] i_q, i_d;
    logic [MSG_WIDTH-1:0] j_q, j_d;
    logic [MSG_WIDTH-1:0] k_q, k_d;
    logic [MSG_WIDTH-1:0] si_old_q, si_old_d;
    logic [MSG_WIDTH-1:0] sj_old_q, sj_old_d;
    logic                 last_pair;

    assign last_pair = ((32'(k_q) + 32'd1) == MSG_DEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            si_old_q <= '0;
            sj_old_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_old_q <= si_old_d;
            sj_old_q <= sj_old_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        si_old_d   = si_old_q;
        sj_old_d   = sj_old_q;
        s_address  = '0;
        s_data     = '0;
        s_wren     = 1'b0;
        mem_req    = owns_mem(state_q);
        s_i        = '0;
        s_j        = '0;
        pair_valid = 1'b0;
        byte_index = k_q;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StIncI;
            end
            StIncI: begin
                i_d     = i_q + MSG_WIDTH'(1);
                state_d = StRdIAddr;
            end
            StRdIAddr: begin
                s_address = i_q;
                state_d   = StRdIWait;
            end
            StRdIWait: begin
                s_address = i_q;
                state_d   = StRdICap;
            end
            // RAM data for the address driven two cycles earlier is valid here.
            StRdICap: begin
                s_address = i_q;
                si_old_d  = s_q;
                j_d       = j_q + s_q;
                state_d   = StRdJAddr;
            end
            StRdJAddr: begin
                s_address = j_q;
                state_d   = StRdJWait;
            end
            StRdJWait: begin
                s_address = j_q;
                state_d   = StRdJCap;
            end
            StRdJCap: begin
                s_address = j_q;
                sj_old_d  = s_q;
                state_d   = StWrI;
            end
            StWrI: begin
                s_address = i_q;
                s_data    = sj_old_q;
                s_wren    = 1'b1;
                state_d   = StWrJ;
            end
            // When i == j this second write restores the original S[i].
            StWrJ: begin
                s_address = j_q;
                s_data    = si_old_q;
                s_wren    = 1'b1;
                state_d   = StPresent;
            end
            StPresent: begin
                s_i        = sj_old_q;
                s_j        = si_old_q;
                pair_valid = 1'b1;
                if (pair_ack) state_d = StNext;
            end
            StNext: begin
                k_d     = k_q + MSG_WIDTH'(1);
                state_d = last_pair ? StDone : StIncI;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_prga_swap_fsm.sv
// Directed bench for prga_swap_fsm against a 2-cycle-latency S RAM model.
module tb_prga_swap_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] s_q;
    logic       pair_ack;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic       mem_req;
    logic [7:0] s_i;
    logic [7:0] s_j;
    logic       pair_valid;
    logic [7:0] byte_index;
    logic       done;

    logic [7:0] mem [256];
    logic [7:0] addr_q;
    logic       do_preset;
    logic       preset_ff;
    logic [7:0] last_wr;
    logic [7:0] prev_wr;

    int total = 0;
    int bad   = 0;

    prga_swap_fsm #(
        .MSG_DEP   (3),
        .MSG_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_q        (s_q),
        .pair_ack   (pair_ack),
        .s_address  (s_address),
        .s_data     (s_data),
        .s_wren     (s_wren),
        .mem_req    (mem_req),
        .s_i        (s_i),
        .s_j        (s_j),
        .pair_valid (pair_valid),
        .byte_index (byte_index),
        .done       (done)
    );

    always #5 clk = ~clk;

    // S RAM: registered address, registered data (two-cycle read latency).
    always @(posedge clk) begin
        if (do_preset) begin
            for (int x = 0; x < 256; x++) mem[x] <= preset_ff ? 8'hff : 8'(x);
        end else if (s_wren) begin
            mem[s_address] <= s_data;
        end
        if (s_wren) begin
            prev_wr <= last_wr;
            last_wr <= s_address;
        end
        addr_q <= s_address;
        s_q    <= mem[addr_q];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_outputs_zero(input string tag);
        check(tag, {s_address, s_data, s_wren, mem_req, s_i, s_j, pair_valid, byte_index, done},
              64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!pair_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, {63'd0, pair_valid}, 64'd1);
    endtask

    task automatic do_reset(input logic ff);
        reset     = 1'b1;
        start     = 1'b0;
        pair_ack  = 1'b1;
        preset_ff = ff;
        do_preset = 1'b1;
        tick();
        tick();
        do_preset = 1'b0;
        reset     = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pair_ack  = 1'b1;
        preset_ff = 1'b0;
        do_preset = 1'b1;
        tick();
        tick();
        all_outputs_zero("in_reset");
        do_preset = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        all_outputs_zero("idle");

        // Pair 0: start sampled on edge 1, pair_valid appears on edge 10.
        pulse_start();
        for (int e = 2; e <= 9; e++) tick();
        check("pv_edge9", {63'd0, pair_valid}, 64'd0);
        tick();
        check("pv_edge10", {63'd0, pair_valid}, 64'd1);
        check("pair0", {s_i, s_j, byte_index}, {40'd0, 8'd1, 8'd1, 8'd0});
        check("pair0_mem", {mem[1], mem_req, s_wren}, {54'd0, 8'd1, 1'b0, 1'b0});
        check("pair0_wr_addr", {prev_wr, last_wr}, {48'd0, 8'd1, 8'd1});

        // Pair 1 with backpressure.
        tick();
        pair_ack = 1'b0;
        wait_valid("pair1");
        check("pair1", {s_i, s_j, byte_index}, {40'd0, 8'd3, 8'd2, 8'd1});
        check("pair1_mem", {mem[2], mem[3]}, {48'd0, 8'd3, 8'd2});
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold", {pair_valid, mem_req, s_wren, s_i, s_j, byte_index, mem[2], mem[3]},
                  {21'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2});
        end
        pair_ack = 1'b1;
        tick();

        wait_valid("pair2");
        check("pair2", {s_i, s_j, byte_index}, {40'd0, 8'd5, 8'd2, 8'd2});
        check("pair2_mem", {mem[2], mem[3], mem[5]}, {40'd0, 8'd3, 8'd5, 8'd2});
        tick();
        check("done_in_next", {62'd0, done, pair_valid}, 64'd0);
        tick();
        check("done_rise", {62'd0, done, pair_valid}, {62'd0, 1'b1, 1'b0});
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("done_hold", {61'd0, done, pair_valid, mem_req}, {61'd0, 1'b1, 1'b0, 1'b0});
        end
        start = 1'b0;

        // Reset asserted during WR_I of pair 1.
        do_reset(1'b0);
        pulse_start();
        wait_valid("rst_pair0");
        tick();
        begin
            int n = 0;
            while (!s_wren && n < 30) begin
                tick();
                n++;
            end
        end
        check("wr_i_found", {55'd0, s_wren, s_address}, {55'd0, 1'b1, 8'd2});
        reset = 1'b1;
        #1;
        all_outputs_zero("async_reset");
        tick();
        all_outputs_zero("reset_held");
        reset = 1'b0;
        tick();
        check("no_wr_i", {mem[2], mem[3]}, {48'd0, 8'd2, 8'd3});
        pulse_start();
        wait_valid("restart_pair0");
        check("restart_pair0", {s_i, s_j, byte_index, prev_wr}, {32'd0, 8'd1, 8'd1, 8'd0, 8'd1});

        // All-255 S: j walks 255, 254, 253.
        do_reset(1'b1);
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            wait_valid("wrap_pair");
            check("wrap_pair", {s_i, s_j, byte_index}, {40'd0, 8'hff, 8'hff, 8'(p)});
            check("wrap_ij", {prev_wr, last_wr}, {48'd0, 8'(p + 1), 8'(255 - p)});
            tick();
        end
        tick();
        check("wrap_done", {63'd0, done}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
